// File: rtl/timeout_scheduler_pkg.sv
// Shared types and limits for the timeout scheduler.
// Channel/global state encodings and width defaults.
package timeout_scheduler_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int MAX_CH         = 16;

  typedef enum logic {
    IDLE,
    ARMED
  } ch_state_e;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    CLR,
    ACK
  } g_state_e;

endpackage

// File: rtl/timeout_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner.
// Generic over N; shared by other single-resource blocks.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_next;
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant    = '0;
    w_ptr_next = r_ptr;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        w_ptr_next     = PW'((int'(w_idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/timeout_scheduler.sv
// NUM_CH timeout channels sharing one free-running timestamp counter.
// Optional TIMEOUT_SCHED_PERIODIC_EN adds auto-rearming periodic channels.
module timeout_scheduler
  import timeout_scheduler_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        now,
  output logic                         counter_clear,
  input  logic                         clear_req,
  output logic                         clear_ack,
  input  logic [NUM_CH-1:0]            arm_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] arm_delay,
`ifdef TIMEOUT_SCHED_PERIODIC_EN
  input  logic [NUM_CH-1:0]            arm_periodic,
`endif
  output logic [NUM_CH-1:0]            arm_ready,
  input  logic [NUM_CH-1:0]            cancel,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH-1:0]            expired
);

  g_state_e          r_gstate;
  g_state_e          w_gnext;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_grant;
  logic [NUM_CH-1:0] w_busy;
  logic              w_run;
  logic              w_any_busy;

  assign w_run      = reset & (r_gstate == RUN);
  assign w_any_busy = |w_busy;
  assign arm_ready  = w_grant;
  assign busy       = w_busy;

  rr_arbiter #(
    .N(NUM_CH)
  ) u_arb (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_req  (w_req),
    .o_grant(w_grant)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_e             r_state;
    logic [DATA_WIDTH-1:0] r_deadline;
    logic [DATA_WIDTH-1:0] w_delay;
    logic [DATA_WIDTH-1:0] w_diff;
    logic                  r_exp;
    logic                  w_cancel;
    logic                  w_fire;
`ifdef TIMEOUT_SCHED_PERIODIC_EN
    logic [DATA_WIDTH-1:0] r_period;
    logic                  r_periodic;
`endif

    // wrap-safe "now >= deadline" for delays below half the range
    assign w_delay   = arm_delay[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_diff    = now - r_deadline;
    assign w_busy[g] = (r_state == ARMED);
    assign w_cancel  = w_busy[g] & cancel[g];
    assign w_fire    = w_busy[g] & ~w_diff[DATA_WIDTH-1] & ~cancel[g];
    assign w_req[g]  = arm_valid[g] & ~w_busy[g] & w_run;
    assign expired[g] = r_exp;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state    <= IDLE;
        r_deadline <= '0;
        r_exp      <= 1'b0;
`ifdef TIMEOUT_SCHED_PERIODIC_EN
        r_period   <= '0;
        r_periodic <= 1'b0;
`endif
      end else begin
        r_exp <= 1'b0;
        unique case (1'b1)
          w_grant[g]: begin
            r_state    <= ARMED;
            r_deadline <= now + w_delay;
`ifdef TIMEOUT_SCHED_PERIODIC_EN
            r_period   <= w_delay;
            r_periodic <= arm_periodic[g] & (|w_delay);
`endif
          end
          w_cancel: begin
            r_state <= IDLE;
          end
          w_fire: begin
            r_exp <= 1'b1;
`ifdef TIMEOUT_SCHED_PERIODIC_EN
            if (r_periodic) begin
              r_deadline <= r_deadline + r_period;
            end else begin
              r_state <= IDLE;
            end
`else
            r_state <= IDLE;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gstate <= RUN;
    end else begin
      r_gstate <= w_gnext;
    end
  end

  // a grant in the same cycle as clear_req must also be drained
  always_comb begin
    w_gnext = r_gstate;
    unique case (r_gstate)
      RUN: begin
        if (clear_req) begin
          w_gnext = (w_any_busy || (|w_grant)) ? DRAIN : CLR;
        end
      end
      DRAIN: begin
        if (!clear_req) begin
          w_gnext = RUN;
        end else if (!w_any_busy) begin
          w_gnext = CLR;
        end
      end
      CLR:     w_gnext = ACK;
      ACK:     w_gnext = RUN;
      default: w_gnext = RUN;
    endcase
  end

  always_comb begin
    counter_clear = 1'b0;
    clear_ack     = 1'b0;
    unique case (r_gstate)
      CLR:     counter_clear = 1'b1;
      ACK:     clear_ack     = 1'b1;
      default: ;
    endcase
  end

endmodule
